// File: rtl/iob_cache_wbuf_pkg.sv
// Shared widths and entry field layout for the cache write-through buffer.
// An entry is packed as {addr, data, strb} with the strobes in the low bits.
package iob_cache_wbuf_pkg;

    localparam int DEF_ADDR_W     = 24;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_DEPTH_LOG2 = 2;

    localparam int STRB_W  = DEF_DATA_W / 8;
    localparam int ENTRY_W = DEF_ADDR_W + DEF_DATA_W + STRB_W;

    localparam int STRB_OFF = 0;

    function automatic int strbW(input int dataW);
        return dataW / 8;
    endfunction

    function automatic int entryW(input int addrW, input int dataW);
        return addrW + dataW + dataW / 8;
    endfunction

    function automatic int dataOff(input int dataW);
        return STRB_OFF + dataW / 8;
    endfunction

    function automatic int addrOff(input int dataW);
        return STRB_OFF + dataW / 8 + dataW;
    endfunction

endpackage

// File: rtl/iob_cache_wbuf_mem.sv
// Entry storage for the write buffer: DEPTH x ENTRY_W registers, one write
// port with an optional byte-merge mode and one asynchronous read port.
// Storage is never reset; validity is tracked by the pointers in the top.
module iob_cache_wbuf_mem
    import iob_cache_wbuf_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = DEF_DEPTH_LOG2
) (
    input  logic                              clk_i,
    input  logic                              we_i,
    input  logic                              merge_i,
    input  logic [IDX_W-1:0]                  waddr_i,
    input  logic [entryW(ADDR_W, DATA_W)-1:0] wdata_i,
    input  logic [IDX_W-1:0]                  raddr_i,
    output logic [entryW(ADDR_W, DATA_W)-1:0] rdata_o
);

    localparam int SW   = strbW(DATA_W);
    localparam int EW   = entryW(ADDR_W, DATA_W);
    localparam int DOFF = dataOff(DATA_W);

    logic [EW-1:0] r_mem [2**IDX_W];

    // Allocate overwrites a whole entry; merge patches strobed bytes and ORs strobes
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            if (merge_i) begin
                for (int b = 0; b < SW; b++) begin
                    if (wdata_i[STRB_OFF+b]) begin
                        r_mem[waddr_i][DOFF+8*b +: 8] <= wdata_i[DOFF+8*b +: 8];
                    end
                end
                r_mem[waddr_i][STRB_OFF +: SW] <=
                    r_mem[waddr_i][STRB_OFF +: SW] | wdata_i[STRB_OFF +: SW];
            end else begin
                r_mem[waddr_i] <= wdata_i;
            end
        end
    end

    assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/iob_reg_cae.sv
// Generic register: async reset, clock enable, sync clear, load enable.
// Async reset wins, then the sync clear (only while clocked), then the load.
module iob_reg_cae #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         arst_i,
    input  logic         cke_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o
);

    // Hold, clear or load depending on reset, clear and enable
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            data_o <= RST_VAL;
        end else if (cke_i) begin
            if (rst_i) begin
                data_o <= RST_VAL;
            end else if (en_i) begin
                data_o <= data_i;
            end
        end
    end

endmodule

// File: rtl/iob_cache_wbuf.sv
// Write-through buffer between the cache front-end and the memory port.
// In-order FIFO of byte-strobed writes with a first-word-fall-through head.
// Optional feature macro: IOB_CACHE_WBUF_COALESCE_EN merges a write into the
// most recently pushed entry when the address matches and at least two
// entries are held (so the head on m_* is never modified).
module iob_cache_wbuf
    import iob_cache_wbuf_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
    input  logic                  clk_i,
    input  logic                  cke_i,
    input  logic                  arst_i,
    input  logic                  rst_i,
    input  logic                  w_valid_i,
    input  logic [ADDR_W-1:0]     w_addr_i,
    input  logic [DATA_W-1:0]     w_data_i,
    input  logic [DATA_W/8-1:0]   w_strb_i,
    output logic                  w_ready_o,
    output logic                  m_valid_o,
    output logic [ADDR_W-1:0]     m_addr_o,
    output logic [DATA_W-1:0]     m_data_o,
    output logic [DATA_W/8-1:0]   m_strb_o,
    input  logic                  m_ready_i,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [DEPTH_LOG2:0]   level_o
);

    localparam int L    = DEPTH_LOG2;
    localparam int PW   = DEPTH_LOG2 + 1;
    localparam int SW   = strbW(DATA_W);
    localparam int EW   = entryW(ADDR_W, DATA_W);
    localparam int DOFF = dataOff(DATA_W);
    localparam int AOFF = addrOff(DATA_W);

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW-1:0] r_level;
    logic [PW-1:0] w_wptrNext;
    logic [PW-1:0] w_rptrNext;
    logic [PW-1:0] w_levelNext;

    logic          w_empty;
    logic          w_full;
    logic          w_merge;
    logic          w_push;
    logic          w_mergeWr;
    logic          w_pop;
    logic          w_memWe;
    logic [L-1:0]  w_memWaddr;
    logic [EW-1:0] w_wEntry;
    logic [EW-1:0] w_head;

    // Pointer comparison: equal means empty, equal index with opposite wrap means full
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[L-1:0] == r_rptr[L-1:0]) && (r_wptr[L] != r_rptr[L]);

`ifdef IOB_CACHE_WBUF_COALESCE_EN
    // Address of the newest entry; only meaningful while two or more are held
    logic [ADDR_W-1:0] r_lastAddr;

    iob_reg_cae #(.W(ADDR_W)) lastAddrReg (
        .clk_i (clk_i),
        .arst_i(arst_i),
        .cke_i (cke_i),
        .rst_i (rst_i),
        .en_i  (w_push),
        .data_i(w_addr_i),
        .data_o(r_lastAddr)
    );

    assign w_merge = w_valid_i && (r_level >= PW'(2)) && (w_addr_i == r_lastAddr);
`else
    assign w_merge = 1'b0;
`endif

    assign w_push    = w_valid_i && !w_full && !w_merge && cke_i;
    assign w_mergeWr = w_valid_i && w_merge && cke_i;
    assign w_pop     = !w_empty && m_ready_i && cke_i;

    assign w_wptrNext  = w_push ? (r_wptr + PW'(1)) : r_wptr;
    assign w_rptrNext  = w_pop  ? (r_rptr + PW'(1)) : r_rptr;
    assign w_levelNext = w_wptrNext - w_rptrNext;

    iob_reg_cae #(.W(PW)) wptrReg (
        .clk_i (clk_i),
        .arst_i(arst_i),
        .cke_i (cke_i),
        .rst_i (rst_i),
        .en_i  (w_push),
        .data_i(w_wptrNext),
        .data_o(r_wptr)
    );

    iob_reg_cae #(.W(PW)) rptrReg (
        .clk_i (clk_i),
        .arst_i(arst_i),
        .cke_i (cke_i),
        .rst_i (rst_i),
        .en_i  (w_pop),
        .data_i(w_rptrNext),
        .data_o(r_rptr)
    );

    iob_reg_cae #(.W(PW)) levelReg (
        .clk_i (clk_i),
        .arst_i(arst_i),
        .cke_i (cke_i),
        .rst_i (rst_i),
        .en_i  (w_push || w_pop),
        .data_i(w_levelNext),
        .data_o(r_level)
    );

    // A merge targets the newest entry, one slot behind the write pointer
    assign w_memWaddr = w_merge ? (r_wptr[L-1:0] - L'(1)) : r_wptr[L-1:0];
    assign w_memWe    = (w_push || w_mergeWr) && !rst_i;
    assign w_wEntry   = {w_addr_i, w_data_i, w_strb_i};

    iob_cache_wbuf_mem #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .IDX_W (L)
    ) storage (
        .clk_i  (clk_i),
        .we_i   (w_memWe),
        .merge_i(w_merge),
        .waddr_i(w_memWaddr),
        .wdata_i(w_wEntry),
        .raddr_i(r_rptr[L-1:0]),
        .rdata_o(w_head)
    );

    assign m_addr_o  = w_head[AOFF +: ADDR_W];
    assign m_data_o  = w_head[DOFF +: DATA_W];
    assign m_strb_o  = w_head[STRB_OFF +: SW];
    assign m_valid_o = !w_empty;
    assign w_ready_o = !w_full || w_merge;
    assign empty_o   = w_empty;
    assign full_o    = w_full;
    assign level_o   = r_level;

endmodule

// File: tb/tb_iob_cache_wbuf.sv
// Self-checking bench for iob_cache_wbuf: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// queue-based model of the buffer contents.
module tb_iob_cache_wbuf;

    localparam int DEPTH = 4;

    typedef struct {
        logic [23:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } entry_t;

    logic        clk;
    logic        cke;
    logic        arst;
    logic        rst;
    logic        wValid;
    logic [23:0] wAddr;
    logic [31:0] wData;
    logic [3:0]  wStrb;
    logic        wReady;
    logic        mValid;
    logic [23:0] mAddr;
    logic [31:0] mData;
    logic [3:0]  mStrb;
    logic        mReady;
    logic        empty;
    logic        full;
    logic [2:0]  level;

    int          errors = 0;
    int          checks = 0;
    logic        checkOn = 1'b0;

    entry_t      q[$];
    entry_t      e;
    logic        doMerge;
    logic        doPop;
    logic        doPush;

    iob_cache_wbuf dut (
        .clk_i    (clk),
        .cke_i    (cke),
        .arst_i   (arst),
        .rst_i    (rst),
        .w_valid_i(wValid),
        .w_addr_i (wAddr),
        .w_data_i (wData),
        .w_strb_i (wStrb),
        .w_ready_o(wReady),
        .m_valid_o(mValid),
        .m_addr_o (mAddr),
        .m_data_o (mData),
        .m_strb_o (mStrb),
        .m_ready_i(mReady),
        .empty_o  (empty),
        .full_o   (full),
        .level_o  (level)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then step to just after the next rising edge
    task automatic applyStimulus(input logic v, input logic [23:0] a, input logic [31:0] d,
                                 input logic [3:0] s, input logic mr, input logic ck,
                                 input logic r);
        wValid = v;
        wAddr  = a;
        wData  = d;
        wStrb  = s;
        mReady = mr;
        cke    = ck;
        rst    = r;
        @(posedge clk);
        #1;
    endtask

    // Model: compare at the falling edge, advance the queue at the rising edge
    always begin
        @(negedge clk);
        if (arst) q.delete();
        if (checkOn) begin
            checkOutput("mdlLevel", 64'(level), 64'(q.size()));
            checkOutput("mdlEmpty", 64'(empty), 64'(q.size() == 0));
            checkOutput("mdlFull", 64'(full), 64'(q.size() == DEPTH));
            checkOutput("mdlMValid", 64'(mValid), 64'(q.size() != 0));
            doMerge = 1'b0;
`ifdef IOB_CACHE_WBUF_COALESCE_EN
            doMerge = wValid && (q.size() >= 2) && (q[q.size()-1].addr == wAddr);
`endif
            checkOutput("mdlWReady", 64'(wReady), 64'((q.size() < DEPTH) || doMerge));
            if (q.size() > 0) begin
                checkOutput("mdlMAddr", 64'(mAddr), 64'(q[0].addr));
                checkOutput("mdlMData", 64'(mData), 64'(q[0].data));
                checkOutput("mdlMStrb", 64'(mStrb), 64'(q[0].strb));
            end
        end
        @(posedge clk);
        if (arst) begin
            q.delete();
        end else if (cke) begin
            if (rst) begin
                q.delete();
            end else begin
                doMerge = 1'b0;
`ifdef IOB_CACHE_WBUF_COALESCE_EN
                doMerge = wValid && (q.size() >= 2) && (q[q.size()-1].addr == wAddr);
`endif
                doPop  = (q.size() > 0) && mReady;
                doPush = wValid && !doMerge && (q.size() < DEPTH);
                if (doMerge) begin
                    e = q[q.size()-1];
                    for (int b = 0; b < 4; b++) begin
                        if (wStrb[b]) e.data[8*b +: 8] = wData[8*b +: 8];
                    end
                    e.strb = e.strb | wStrb;
                    q[q.size()-1] = e;
                end
                if (doPop) void'(q.pop_front());
                if (doPush) begin
                    e.addr = wAddr;
                    e.data = wData;
                    e.strb = wStrb;
                    q.push_back(e);
                end
            end
        end
    end

    // Directed scenarios, then randomized traffic, then the summary
    initial begin
        wValid = 1'b0;
        wAddr  = '0;
        wData  = '0;
        wStrb  = '0;
        mReady = 1'b0;
        cke    = 1'b1;
        rst    = 1'b0;
        arst   = 1'b0;
        #1 arst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 arst = 1'b0;
        checkOn = 1'b1;

        checkOutput("rstEmpty", 64'(empty), 64'h1);
        checkOutput("rstFull", 64'(full), 64'h0);
        checkOutput("rstWReady", 64'(wReady), 64'h1);
        checkOutput("rstMValid", 64'(mValid), 64'h0);
        checkOutput("rstLevel", 64'(level), 64'h0);

        // Fill to full, then a blocked fifth push
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 24'(16 + i), $urandom, 4'hF, 1'b0, 1'b1, 1'b0);
        end
        checkOutput("fillLevel", 64'(level), 64'h4);
        checkOutput("fillFull", 64'(full), 64'h1);
        checkOutput("fillWReady", 64'(wReady), 64'h0);
        applyStimulus(1'b1, 24'h99, $urandom, 4'hF, 1'b0, 1'b1, 1'b0);
        checkOutput("blockedLevel", 64'(level), 64'h4);

        // Drain in order
        for (int i = 0; i < 4; i++) begin
            checkOutput("drainHead", 64'(mAddr), 64'(16 + i));
            applyStimulus(1'b0, 24'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0);
        end
        checkOutput("drainEmpty", 64'(empty), 64'h1);
        checkOutput("drainMValid", 64'(mValid), 64'h0);

        // Steady state at level 2 with wrap-around
        applyStimulus(1'b1, 24'h30, $urandom, 4'hF, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 24'h31, $urandom, 4'hF, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            checkOutput("steadyLevel", 64'(level), 64'h2);
            checkOutput("steadyHead", 64'(mAddr), 64'(48 + i));
            applyStimulus(1'b1, 24'(50 + i), $urandom, 4'(i), 1'b1, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 24'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 24'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0);

        // Sync clear beats a coincident push
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 24'(64 + i), $urandom, 4'hF, 1'b0, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 24'h43, $urandom, 4'hF, 1'b0, 1'b1, 1'b1);
        checkOutput("clrLevel", 64'(level), 64'h0);
        checkOutput("clrEmpty", 64'(empty), 64'h1);
        applyStimulus(1'b0, 24'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0);
        checkOutput("clrMValid", 64'(mValid), 64'h0);

        // Clock enable low freezes everything
        applyStimulus(1'b1, 24'h50, $urandom, 4'hF, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 24'h51, $urandom, 4'hF, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 24'h60, $urandom, 4'hF, 1'b1, 1'b0, 1'b0);
            checkOutput("ckeLevel", 64'(level), 64'h2);
            checkOutput("ckeHead", 64'(mAddr), 64'h50);
        end
        applyStimulus(1'b1, 24'h61, $urandom, 4'hF, 1'b1, 1'b1, 1'b0);
        checkOutput("resumeLevel", 64'(level), 64'h2);
        checkOutput("resumeHead", 64'(mAddr), 64'h51);
        applyStimulus(1'b0, 24'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 24'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0);
        checkOutput("resumeEmpty", 64'(empty), 64'h1);

`ifdef IOB_CACHE_WBUF_COALESCE_EN
        // Partial write merges into the newest entry
        applyStimulus(1'b1, 24'h20, 32'h11223344, 4'hF, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 24'h21, 32'hAABBCCDD, 4'hF, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 24'h21, 32'h000000EE, 4'h1, 1'b0, 1'b1, 1'b0);
        checkOutput("coalLevel", 64'(level), 64'h2);
        applyStimulus(1'b0, 24'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0);
        checkOutput("coalAddr", 64'(mAddr), 64'h21);
        checkOutput("coalData", 64'(mData), 64'hAABBCCEE);
        checkOutput("coalStrb", 64'(mStrb), 64'hF);
        applyStimulus(1'b0, 24'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0);
`endif

        // Randomized traffic with occasional clears and async resets
        for (int i = 0; i < 800; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 24'($urandom_range(0, 3)), $urandom,
                          4'($urandom_range(0, 15)), 1'($urandom_range(0, 2) == 0),
                          1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 39) == 0));
            if ($urandom_range(0, 99) == 0) begin
                arst = 1'b1;
                @(posedge clk);
                #1 arst = 1'b0;
            end
        end

        applyStimulus(1'b0, 24'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
